// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type and address-width helpers for the convolution sequencer
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } state_e;

    localparam int CNT_W = 4;

    // Never returns zero so single-entry memories still get a 1-bit address.
    function automatic int addr_w(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

    function automatic int img_aw(input int img_dim);
        return addr_w(img_dim * img_dim);
    endfunction

    function automatic int ker_aw(input int ker_dim);
        return addr_w(ker_dim * ker_dim);
    endfunction

    function automatic int out_aw(input int img_dim, input int ker_dim);
        return addr_w((img_dim - ker_dim + 1) * (img_dim - ker_dim + 1));
    endfunction

endpackage

// File: rtl/conv_ctrl_if.sv
// rtl/conv_ctrl_if.sv - start/status and memory-strobe bundle between conv_ctrl and its datapath
interface conv_ctrl_if
    import conv_pkg::*;
#(
    parameter int IMG_DIM = 8,
    parameter int KER_DIM = 3
) ();

    localparam int IMG_AW = img_aw(IMG_DIM);
    localparam int KER_AW = ker_aw(KER_DIM);
    localparam int OUT_AW = out_aw(IMG_DIM, KER_DIM);

    logic              start;
    logic              busy;
    logic              done;
    logic [IMG_AW-1:0] img_addr;
    logic [KER_AW-1:0] ker_addr;
    logic              rd_vld;
    logic              acc_clr;
    logic              acc_en;
    logic              out_wr;
    logic [OUT_AW-1:0] out_addr;

    modport master (
        input  start,
        output busy, done, img_addr, ker_addr, rd_vld,
        output acc_clr, acc_en, out_wr, out_addr
    );

    modport slave (
        output start,
        input  busy, done, img_addr, ker_addr, rd_vld,
        input  acc_clr, acc_en, out_wr, out_addr
    );

endinterface

// File: rtl/conv_loop_counter.sv
// rtl/conv_loop_counter.sv - bounded loop index with terminal-count flag for carry chaining
module conv_loop_counter #(
    parameter int LIMIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] cnt,
    output logic       tc
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign tc  = (cnt_q == 4'(LIMIT - 1));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? 4'd0 : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_ctrl.sv
// rtl/conv_ctrl.sv - loop-nest sequencer for one 2-D valid convolution
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_DIM = 8,
    parameter int KER_DIM = 3
) (
    input  logic            clk,
    input  logic            rst,
    conv_ctrl_if.master     bus
);

    localparam int OUT_DIM = IMG_DIM - KER_DIM + 1;
    localparam int IMG_AW  = img_aw(IMG_DIM);
    localparam int KER_AW  = ker_aw(KER_DIM);
    localparam int OUT_AW  = out_aw(IMG_DIM, KER_DIM);

    state_e state_q, state_d;
    logic   acc_en_q, acc_en_d;

    logic [3:0] kc, kr, oc, orow;
    logic       kc_tc, kr_tc, oc_tc, or_tc;
    logic       ker_clr, out_clr, kc_en, oc_en;

    always_comb begin
        state_d = state_q;
        ker_clr = 1'b0;
        out_clr = 1'b0;
        kc_en   = 1'b0;
        oc_en   = 1'b0;
        unique case (state_q)
            IDLE:  if (bus.start) state_d = INIT;
            INIT: begin
                ker_clr = 1'b1;
                out_clr = 1'b1;
                state_d = MAC;
            end
            MAC: begin
                kc_en = 1'b1;
                if (kc_tc && kr_tc) state_d = DRAIN;
            end
            DRAIN: state_d = WRITE;
            // Kernel counters already wrapped on the last tap; clearing again keeps MAC entry exact.
            WRITE: begin
                oc_en   = 1'b1;
                ker_clr = 1'b1;
                state_d = (oc_tc && or_tc) ? DONE : MAC;
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign acc_en_d = (state_q == MAC);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            acc_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_en_q <= acc_en_d;
        end
    end

    conv_loop_counter #(.LIMIT(KER_DIM)) u_kc (
        .clk(clk), .rst(rst), .clr(ker_clr), .en(kc_en),          .cnt(kc),   .tc(kc_tc)
    );
    conv_loop_counter #(.LIMIT(KER_DIM)) u_kr (
        .clk(clk), .rst(rst), .clr(ker_clr), .en(kc_en && kc_tc), .cnt(kr),   .tc(kr_tc)
    );
    conv_loop_counter #(.LIMIT(OUT_DIM)) u_oc (
        .clk(clk), .rst(rst), .clr(out_clr), .en(oc_en),          .cnt(oc),   .tc(oc_tc)
    );
    conv_loop_counter #(.LIMIT(OUT_DIM)) u_or (
        .clk(clk), .rst(rst), .clr(out_clr), .en(oc_en && oc_tc), .cnt(orow), .tc(or_tc)
    );

    logic [IMG_AW-1:0] img_lin;
    logic [KER_AW-1:0] ker_lin;
    logic [OUT_AW-1:0] out_lin;

    // All sums stay below the memory size, so each address width holds them without wrap.
    assign img_lin = (IMG_AW'(orow) + IMG_AW'(kr)) * IMG_AW'(IMG_DIM) + IMG_AW'(oc) + IMG_AW'(kc);
    assign ker_lin = KER_AW'(kr) * KER_AW'(KER_DIM) + KER_AW'(kc);
    assign out_lin = OUT_AW'(orow) * OUT_AW'(OUT_DIM) + OUT_AW'(oc);

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.rd_vld   = (state_q == MAC);
    assign bus.acc_clr  = (state_q == INIT) || (state_q == WRITE);
    assign bus.acc_en   = acc_en_q;
    assign bus.out_wr   = (state_q == WRITE);
    assign bus.img_addr = (state_q == MAC)   ? img_lin : '0;
    assign bus.ker_addr = (state_q == MAC)   ? ker_lin : '0;
    assign bus.out_addr = (state_q == WRITE) ? out_lin : '0;

endmodule

// File: tb/tb_conv_ctrl.sv
// tb/tb_conv_ctrl.sv - randomized bench for conv_ctrl against a cycle-index model
module tb_conv_ctrl;

    localparam int IMG      = 8;
    localparam int KER      = 3;
    localparam int OD       = IMG - KER + 1;
    localparam int P        = KER * KER + 2;
    localparam int NOUT     = OD * OD;
    localparam int DONE_REL = 2 + NOUT * P;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    conv_ctrl_if #(.IMG_DIM(IMG), .KER_DIM(KER)) bus ();
    conv_ctrl_if #(.IMG_DIM(4),   .KER_DIM(4))   bus2 ();

    conv_ctrl #(.IMG_DIM(IMG), .KER_DIM(KER)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
    conv_ctrl #(.IMG_DIM(4), .KER_DIM(4)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.master)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int busy, done, rd_vld, acc_clr, out_wr, img, ker, oaddr;
    } exp_t;

    // rel = cycles since start was sampled; -1 means idle.
    function automatic exp_t expect_at(input int rel);
        exp_t e;
        int   n, j;
        e = '{default: 0};
        if (rel >= 1) begin
            e.busy = 1;
            if (rel == 1) begin
                e.acc_clr = 1;
            end else if (rel == DONE_REL) begin
                e.done = 1;
            end else begin
                n = (rel - 2) / P;
                j = (rel - 2) % P;
                if (j < KER * KER) begin
                    e.rd_vld = 1;
                    e.img    = ((n / OD) + j / KER) * IMG + (n % OD) + j % KER;
                    e.ker    = j;
                end else if (j == KER * KER + 1) begin
                    e.out_wr  = 1;
                    e.acc_clr = 1;
                    e.oaddr   = n;
                end
            end
        end
        return e;
    endfunction

    function automatic int rd_at(input int rel);
        exp_t t;
        t = expect_at(rel);
        return t.rd_vld;
    endfunction

    int m_rel  = -1;
    int m_acc  = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_rel <= -1;
            m_acc <= 0;
        end else begin
            m_acc <= rd_at(m_rel);
            if (m_rel < 0)              m_rel <= bus.start ? 1 : -1;
            else if (m_rel == DONE_REL) m_rel <= -1;
            else                        m_rel <= m_rel + 1;
        end
    end

    exp_t ce;
    always @(negedge clk) begin
        if (chk_en) begin
            ce = expect_at(m_rel);
            check("busy",     int'(bus.busy),     ce.busy);
            check("done",     int'(bus.done),     ce.done);
            check("rd_vld",   int'(bus.rd_vld),   ce.rd_vld);
            check("acc_clr",  int'(bus.acc_clr),  ce.acc_clr);
            check("acc_en",   int'(bus.acc_en),   m_acc);
            check("out_wr",   int'(bus.out_wr),   ce.out_wr);
            check("img_addr", int'(bus.img_addr), ce.img);
            check("ker_addr", int'(bus.ker_addr), ce.ker);
            check("out_addr", int'(bus.out_addr), ce.oaddr);
        end
    end

    int done_rel, n_done, n_wr, wr_bad, n_rd, first35, last35, acc0, t0;
    int img0[$];
    int ker0[$];
    int img0_exp[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    task automatic collect_run(input string tag);
        int rel;
        done_rel = -1; n_done = 0; n_wr = 0; wr_bad = 0; n_rd = 0;
        first35 = -1; last35 = -1; acc0 = 0;
        img0.delete(); ker0.delete();
        @(negedge clk);
        bus.start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < DONE_REL + 40; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            rel = cyc - t0;
            if (bus.done) begin
                n_done++;
                if (done_rel < 0) done_rel = rel;
            end
            if (bus.out_wr) begin
                if (int'(bus.out_addr) != n_wr) wr_bad++;
                n_wr++;
            end
            if (bus.rd_vld) begin
                n_rd++;
                if (n_rd <= 9) begin
                    img0.push_back(int'(bus.img_addr));
                    ker0.push_back(int'(bus.ker_addr));
                end
                if (n_rd == 316) first35 = int'(bus.img_addr);
                if (n_rd == 324) last35  = int'(bus.img_addr);
            end
            if (rel >= 2 && rel <= 12) acc0 = (acc0 << 1) | int'(bus.acc_en);
        end
        check({tag, "_done_cycle"}, done_rel, 398);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_wr_count"}, n_wr, 36);
        check({tag, "_wr_order"}, wr_bad, 0);
        check({tag, "_rd_cycles"}, n_rd, 324);
        check({tag, "_out35_first_img"}, first35, 45);
        check({tag, "_out35_last_img"}, last35, 63);
        check({tag, "_out0_acc_en_bits"}, acc0, 'h3FE);
        check({tag, "_out0_len"}, img0.size(), 9);
        if (img0.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                check({tag, "_out0_img"}, img0[i], img0_exp[i]);
                check({tag, "_out0_ker"}, ker0[i], i);
            end
        end
    endtask

    bit dut2_done = 1'b0;

    initial begin
        int rel2, t2, d2, nd2, nrd2, bad2, nwr2, oa2;
        d2 = -1; nd2 = 0; nrd2 = 0; bad2 = 0; nwr2 = 0; oa2 = -1;
        bus2.start = 1'b0;
        wait (chk_en);
        @(negedge clk);
        bus2.start = 1'b1;
        t2 = cyc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus2.start = 1'b0;
            rel2 = cyc - t2;
            if (bus2.done) begin
                nd2++;
                d2 = rel2;
            end
            if (bus2.rd_vld) begin
                if (int'(bus2.img_addr) != nrd2 || int'(bus2.ker_addr) != nrd2) bad2++;
                nrd2++;
            end
            if (bus2.out_wr) begin
                nwr2++;
                oa2 = int'(bus2.out_addr);
            end
        end
        check("k4_done_cycle", d2, 20);
        check("k4_done_count", nd2, 1);
        check("k4_rd_cycles", nrd2, 16);
        check("k4_addr_seq", bad2, 0);
        check("k4_wr_count", nwr2, 1);
        check("k4_out_addr", oa2, 0);
        dut2_done = 1'b1;
    end

    initial begin
        int rel, d1, rise, nd, n_stray;
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_acc_en", int'(bus.acc_en), 0);
        rst = 1'b1;
        chk_en = 1'b1;

        collect_run("run1");

        // start held high: back-to-back runs separated by one IDLE cycle
        d1 = -1; rise = -1; nd = 0;
        @(negedge clk);
        bus.start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (bus.done) begin
                nd++;
                if (d1 < 0) d1 = rel;
            end
            if (d1 >= 0 && rel > d1 && rise < 0 && bus.busy) rise = rel;
        end
        bus.start = 1'b0;
        check("hold_first_done", d1, 398);
        check("hold_second_init", rise, 400);
        check("hold_done_count", nd, 2);
        for (int i = 0; i < 500 && bus.busy; i++) @(negedge clk);
        check("hold_drained", int'(bus.busy), 0);

        // abort during MAC of output 10, then rerun from scratch
        @(negedge clk);
        bus.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 200 && (cyc - t0) < 115; i++) @(negedge clk);
        check("abort_in_mac", int'(bus.rd_vld), 1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_acc_en", int'(bus.acc_en), 0);
        check("abort_img_addr", int'(bus.img_addr), 0);
        rst = 1'b1;
        n_stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_wr || bus.done || bus.busy) n_stray++;
        end
        check("abort_quiet", n_stray, 0);
        collect_run("rerun");

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 500 && bus.busy; i++) @(negedge clk);
        check("random_drained", int'(bus.busy), 0);

        check("k4_finished", int'(dut2_done), 1);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_ctrl.md
# conv_ctrl

Sequencer for one 2-D valid convolution of a square image with a square kernel. The block walks the output-row/column and kernel-row/column loop nest, issues image and kernel read addresses, and drives accumulator clear/enable and output-memory write strobes. Every loop index sits in a small bounded counter with a terminal-count flag, chained carry-style.

## Interface
- IMG_DIM, 8, image side length in pixels; 2..16.
- KER_DIM, 3, kernel side length; 1..IMG_DIM.
- OUT_DIM (local), IMG_DIM-KER_DIM+1, output side length.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock, reset synchronous and active-low (rst=0 resets on the rising edge).
- start  in  1  begin a convolution; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last output has been written.
- img_addr  out  clog2(IMG_DIM²)  image read address, row-major.
- ker_addr  out  clog2(KER_DIM²)  kernel read address, row-major.
- rd_vld  out  1  img_addr/ker_addr valid this cycle.
- acc_clr  out  1  accumulator clear.
- acc_en  out  1  accumulate the product of data returned for the previous cycle's addresses.
- out_wr  out  1  write the accumulator value to output memory.
- out_addr  out  clog2(OUT_DIM²)  output write address, row-major.

## Operation
- States and transitions:
  - IDLE → INIT when start=1.
  - INIT: 1 cycle. Clears all loop counters; acc_clr=1. → MAC.
  - MAC: 1 cycle per kernel tap, rd_vld=1.
    - img_addr = (or+kr)·IMG_DIM + (oc+kc).
    - ker_addr = kr·KER_DIM + kc.
    - kc increments every cycle. On kc terminal (KER_DIM-1), kc wraps to 0 and kr increments.
    - When both are terminal → DRAIN.
  - DRAIN: 1 cycle, rd_vld=0. Covers memory latency for the last tap. → WRITE.
  - WRITE: 1 cycle.
    - out_wr=1, out_addr = or·OUT_DIM + oc.
    - acc_clr=1. The write captures the pre-edge accumulator value; the clear takes effect at the same edge.
    - oc increments. On oc terminal it wraps and or increments.
    - If or and oc were both terminal → DONE, else → MAC.
  - DONE: done=1 for 1 cycle. → IDLE.
- Memory read latency is fixed at 1 cycle: acc_en is rd_vld registered by one cycle.
- Kernel counters reset to 0 on every MAC entry.
- Address arithmetic uses unsigned widths sized by clog2. Sums never exceed IMG_DIM²-1, so there is no truncation.
- start is ignored while busy=1, including during DONE.
- A start held high continuously restarts one cycle after DONE (IDLE is visited for 1 cycle).

## Timing
- Reset (rst=0 at an edge): state=IDLE, all counters 0, and every output 0 (busy, done, rd_vld, acc_clr, acc_en, out_wr, all addresses).
- Reset mid-operation aborts immediately. No write, no done pulse. The pending acc_en is also cleared.
- Let cycle 0 be the cycle in which start is sampled:
  - INIT occupies cycle 1.
  - Output n occupies cycles 2+n·(K²+2) .. 1+(n+1)·(K²+2), where K = KER_DIM.
  - done is high in cycle 2 + OUT_DIM²·(KER_DIM²+2).
- acc_en lags rd_vld by exactly 1 cycle. acc_en is high in DRAIN and low in WRITE.
- Outputs are registered/state-decoded with no combinational path from start.
- Minimum configuration KER_DIM=1: MAC is 1 cycle and each output takes 3 cycles.
- Configuration KER_DIM=IMG_DIM: OUT_DIM=1, a single output.

## Structure
- Shared package conv_pkg holds:
  - the state enum (IDLE, INIT, MAC, DRAIN, WRITE, DONE);
  - the clog2-based address-width helper functions.
- One sub-module, conv_loop_counter.
  - Parameter LIMIT.
  - 4-bit output. Ports: clk, rst (sync active-low), clr, en, cnt, tc.
  - tc = (cnt==LIMIT-1); it wraps to 0 on en&tc.
  - Four instances, chained by tc: kc→kr and oc→or.

## Test plan
- Default params, start pulse at cycle 0:
  - done is high only in cycle 398.
  - There are exactly 36 out_wr pulses with out_addr 0..35 in order.
  - rd_vld is high for 324 cycles.
- Output 0:
  - img_addr sequence is 0,1,2,8,9,10,16,17,18.
  - ker_addr sequence is 0..8.
  - acc_en sequence is 0,1×9, then 0 in WRITE.
- Output 35 (or=5, oc=5): first img_addr=45, last img_addr=63.
- start held high for 1000 cycles:
  - The second run's INIT begins 2 cycles after the first done (DONE, then IDLE).
  - Extra start pulses while busy have no effect.
- rst=0 during MAC of output 10, then released:
  - All outputs are 0 in the next cycle.
  - No out_wr or done occurs until a new start.
  - The restarted run matches the first run cycle-for-cycle.
- IMG_DIM=4, KER_DIM=4:
  - One output; done is in cycle 20.
  - img_addr runs 0..15 and out_addr=0.
